adam_axil_skid: RTL and testbench

ADAM_AXIL_SKID -- requirements
Module: adam_axil_skid

---
 rtl/adam_axil_skid_pkg.sv | 28 ++
 rtl/AXI_LITE.sv | 40 ++++
 rtl/adam_skid.sv | 62 ++++++
 rtl/adam_axil_skid.sv | 63 ++++++
 tb/tb_adam_axil_skid.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adam_axil_skid_pkg.sv
// adam_axil_skid_pkg: shared AXI-Lite widths and per-channel payload structs
package adam_axil_skid_pkg;
    localparam int AXIL_ADDR_WIDTH = 32;
    localparam int AXIL_DATA_WIDTH = 32;
    localparam int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;
    typedef logic [AXIL_ADDR_WIDTH-1:0] addr_t;
    typedef logic [2:0]                 prot_t;
    typedef logic [AXIL_DATA_WIDTH-1:0] data_t;
    typedef logic [AXIL_STRB_WIDTH-1:0] strb_t;
    typedef logic [1:0]                 resp_t;
    typedef struct packed {
        addr_t addr;
        prot_t prot;
    } ax_chan_t;
    typedef ax_chan_t aw_chan_t;
    typedef ax_chan_t ar_chan_t;
    typedef struct packed {
        data_t data;
        strb_t strb;
    } w_chan_t;
    typedef struct packed {
        resp_t resp;
    } b_chan_t;
    typedef struct packed {
        data_t data;
        resp_t resp;
    } r_chan_t;
endpackage

// File: rtl/AXI_LITE.sv
// AXI_LITE: AXI-Lite bus bundle with master and slave views
interface AXI_LITE #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]            aw_prot;
    logic                  aw_valid;
    logic                  aw_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_valid;
    logic                  w_ready;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]            ar_prot;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_valid;
    logic                  r_ready;
    modport master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );
    modport slave (
        input aw_addr, aw_prot, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface

// File: rtl/adam_skid.sv
// adam_skid: generic 2-entry skid buffer with registered valid/ready, or a wire-through
module adam_skid #(
    parameter type T      = logic,
    parameter bit  BYPASS = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    if (BYPASS) begin : g_bypass
        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;
    end else begin : g_buf
        logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_fire;
        T     out_data_q, out_data_d, skid_data_q, skid_data_d;
        assign in_fire   = in_valid && in_ready_q;
        assign out_valid = out_valid_q;
        assign out_data  = out_data_q;
        assign in_ready  = in_ready_q;
        // refill the output slot from skid first (keeps order), else park a stalled arrival in skid
        always_comb begin
            out_valid_d  = out_valid_q;
            skid_valid_d = skid_valid_q;
            out_data_d   = out_data_q;
            skid_data_d  = skid_data_q;
            if (!out_valid_q || out_ready) begin
                if (skid_valid_q) begin
                    out_data_d   = skid_data_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = in_fire;
                    out_data_d  = in_fire ? in_data : out_data_q;
                end
            end else if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end
        // state registers; ready is registered from next skid occupancy so it never depends on out_ready
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b0;
                out_data_q   <= '0;
                skid_data_q  <= '0;
            end else begin
                out_valid_q  <= out_valid_d;
                skid_valid_q <= skid_valid_d;
                in_ready_q   <= !skid_valid_d;
                out_data_q   <= out_data_d;
                skid_data_q  <= skid_data_d;
            end
        end
    end
endmodule

// File: rtl/adam_axil_skid.sv
// adam_axil_skid: AXI-Lite register slice, one independent skid buffer per channel
module adam_axil_skid
    import adam_axil_skid_pkg::*;
#(
    parameter int ADDR_WIDTH = AXIL_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXIL_DATA_WIDTH,
    parameter bit BYPASS_AW  = 1'b0,
    parameter bit BYPASS_W   = 1'b0,
    parameter bit BYPASS_B   = 1'b0,
    parameter bit BYPASS_AR  = 1'b0,
    parameter bit BYPASS_R   = 1'b0
) (
    input logic     clk,
    input logic     rst_n,
    AXI_LITE.slave  slv,
    AXI_LITE.master mst
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    aw_chan_t aw_in, aw_out;
    w_chan_t  w_in, w_out;
    b_chan_t  b_in, b_out;
    ar_chan_t ar_in, ar_out;
    r_chan_t  r_in, r_out;
    assign aw_in = '{addr: addr_t'(slv.aw_addr), prot: slv.aw_prot};
    assign w_in  = '{data: data_t'(slv.w_data), strb: strb_t'(slv.w_strb)};
    assign b_in  = '{resp: mst.b_resp};
    assign ar_in = '{addr: addr_t'(slv.ar_addr), prot: slv.ar_prot};
    assign r_in  = '{data: data_t'(mst.r_data), resp: mst.r_resp};
    assign mst.aw_addr = ADDR_WIDTH'(aw_out.addr);
    assign mst.aw_prot = aw_out.prot;
    assign mst.w_data  = DATA_WIDTH'(w_out.data);
    assign mst.w_strb  = STRB_WIDTH'(w_out.strb);
    assign slv.b_resp  = b_out.resp;
    assign mst.ar_addr = ADDR_WIDTH'(ar_out.addr);
    assign mst.ar_prot = ar_out.prot;
    assign slv.r_data  = DATA_WIDTH'(r_out.data);
    assign slv.r_resp  = r_out.resp;
    adam_skid #(.T(aw_chan_t), .BYPASS(BYPASS_AW)) u_aw (
        .clk(clk), .rst_n(rst_n),
        .in_valid(slv.aw_valid), .in_ready(slv.aw_ready), .in_data(aw_in),
        .out_valid(mst.aw_valid), .out_ready(mst.aw_ready), .out_data(aw_out)
    );
    adam_skid #(.T(w_chan_t), .BYPASS(BYPASS_W)) u_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(slv.w_valid), .in_ready(slv.w_ready), .in_data(w_in),
        .out_valid(mst.w_valid), .out_ready(mst.w_ready), .out_data(w_out)
    );
    adam_skid #(.T(b_chan_t), .BYPASS(BYPASS_B)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(mst.b_valid), .in_ready(mst.b_ready), .in_data(b_in),
        .out_valid(slv.b_valid), .out_ready(slv.b_ready), .out_data(b_out)
    );
    adam_skid #(.T(ar_chan_t), .BYPASS(BYPASS_AR)) u_ar (
        .clk(clk), .rst_n(rst_n),
        .in_valid(slv.ar_valid), .in_ready(slv.ar_ready), .in_data(ar_in),
        .out_valid(mst.ar_valid), .out_ready(mst.ar_ready), .out_data(ar_out)
    );
    adam_skid #(.T(r_chan_t), .BYPASS(BYPASS_R)) u_r (
        .clk(clk), .rst_n(rst_n),
        .in_valid(mst.r_valid), .in_ready(mst.r_ready), .in_data(r_in),
        .out_valid(slv.r_valid), .out_ready(slv.r_ready), .out_data(r_out)
    );
endmodule

// File: tb/tb_adam_axil_skid.sv
// tb_adam_axil_skid: randomized check of the AXI-Lite skid slice against a FIFO reference model
module tb_adam_axil_skid;
    localparam int PW [5] = '{35, 36, 2, 35, 34};
    localparam logic [35:0] BASIC [5] = '{36'h0_1234_5678, 36'hF_DEAD_BEEF, 36'h0, 36'h2_A5A5_0004, 36'h0_CAFE_0001};
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    // index [d][c]: d=0 buffered DUT, d=1 all-bypass DUT; c = AW, W, B, AR, R
    logic        src_valid [2][5];
    logic [35:0] src_data  [2][5];
    logic        src_ready [2][5];
    logic        snk_valid [2][5];
    logic [35:0] snk_data  [2][5];
    logic        snk_ready [2][5];
    AXI_LITE slv0 (), mst0 (), slv1 (), mst1 ();
    adam_axil_skid u_dut (.clk(clk), .rst_n(rst_n), .slv(slv0), .mst(mst0));
    adam_axil_skid #(
        .BYPASS_AW(1'b1), .BYPASS_W(1'b1), .BYPASS_B(1'b1), .BYPASS_AR(1'b1), .BYPASS_R(1'b1)
    ) u_byp (.clk(clk), .rst_n(rst_n), .slv(slv1), .mst(mst1));
    assign slv0.aw_valid = src_valid[0][0];
    assign {slv0.aw_prot, slv0.aw_addr} = src_data[0][0][34:0];
    assign src_ready[0][0] = slv0.aw_ready;
    assign mst0.aw_ready = snk_ready[0][0];
    assign snk_valid[0][0] = mst0.aw_valid;
    assign snk_data[0][0] = {1'b0, mst0.aw_prot, mst0.aw_addr};
    assign slv0.w_valid = src_valid[0][1];
    assign {slv0.w_strb, slv0.w_data} = src_data[0][1];
    assign src_ready[0][1] = slv0.w_ready;
    assign mst0.w_ready = snk_ready[0][1];
    assign snk_valid[0][1] = mst0.w_valid;
    assign snk_data[0][1] = {mst0.w_strb, mst0.w_data};
    assign mst0.b_valid = src_valid[0][2];
    assign mst0.b_resp = src_data[0][2][1:0];
    assign src_ready[0][2] = mst0.b_ready;
    assign slv0.b_ready = snk_ready[0][2];
    assign snk_valid[0][2] = slv0.b_valid;
    assign snk_data[0][2] = {34'd0, slv0.b_resp};
    assign slv0.ar_valid = src_valid[0][3];
    assign {slv0.ar_prot, slv0.ar_addr} = src_data[0][3][34:0];
    assign src_ready[0][3] = slv0.ar_ready;
    assign mst0.ar_ready = snk_ready[0][3];
    assign snk_valid[0][3] = mst0.ar_valid;
    assign snk_data[0][3] = {1'b0, mst0.ar_prot, mst0.ar_addr};
    assign mst0.r_valid = src_valid[0][4];
    assign {mst0.r_resp, mst0.r_data} = src_data[0][4][33:0];
    assign src_ready[0][4] = mst0.r_ready;
    assign slv0.r_ready = snk_ready[0][4];
    assign snk_valid[0][4] = slv0.r_valid;
    assign snk_data[0][4] = {2'd0, slv0.r_resp, slv0.r_data};
    assign slv1.aw_valid = src_valid[1][0];
    assign {slv1.aw_prot, slv1.aw_addr} = src_data[1][0][34:0];
    assign src_ready[1][0] = slv1.aw_ready;
    assign mst1.aw_ready = snk_ready[1][0];
    assign snk_valid[1][0] = mst1.aw_valid;
    assign snk_data[1][0] = {1'b0, mst1.aw_prot, mst1.aw_addr};
    assign slv1.w_valid = src_valid[1][1];
    assign {slv1.w_strb, slv1.w_data} = src_data[1][1];
    assign src_ready[1][1] = slv1.w_ready;
    assign mst1.w_ready = snk_ready[1][1];
    assign snk_valid[1][1] = mst1.w_valid;
    assign snk_data[1][1] = {mst1.w_strb, mst1.w_data};
    assign mst1.b_valid = src_valid[1][2];
    assign mst1.b_resp = src_data[1][2][1:0];
    assign src_ready[1][2] = mst1.b_ready;
    assign slv1.b_ready = snk_ready[1][2];
    assign snk_valid[1][2] = slv1.b_valid;
    assign snk_data[1][2] = {34'd0, slv1.b_resp};
    assign slv1.ar_valid = src_valid[1][3];
    assign {slv1.ar_prot, slv1.ar_addr} = src_data[1][3][34:0];
    assign src_ready[1][3] = slv1.ar_ready;
    assign mst1.ar_ready = snk_ready[1][3];
    assign snk_valid[1][3] = mst1.ar_valid;
    assign snk_data[1][3] = {1'b0, mst1.ar_prot, mst1.ar_addr};
    assign mst1.r_valid = src_valid[1][4];
    assign {mst1.r_resp, mst1.r_data} = src_data[1][4][33:0];
    assign src_ready[1][4] = mst1.r_ready;
    assign slv1.r_ready = snk_ready[1][4];
    assign snk_valid[1][4] = slv1.r_valid;
    assign snk_data[1][4] = {2'd0, slv1.r_resp, slv1.r_data};
    // reference model for the buffered DUT: beats accepted but not yet delivered, in arrival order
    logic [35:0] mq [5][$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 5; c++) mq[c].delete();
        end else begin
            for (int c = 0; c < 5; c++) begin
                if (snk_valid[0][c] && snk_ready[0][c] && mq[c].size() > 0) void'(mq[c].pop_front());
                if (src_valid[0][c] && src_ready[0][c]) mq[c].push_back(src_data[0][c]);
            end
        end
    end
    function automatic logic [35:0] rnd_pay(int c);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[35:0] & ((36'h1 << PW[c]) - 36'h1);
    endfunction
    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_cmp += 2;
            if (src_ready[0][c] !== 1'b0) begin n_err++; $display("FAIL reset_in_ready ch%0d got %b want 0", c, src_ready[0][c]); end
            if (snk_valid[0][c] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid ch%0d got %b want 0", c, snk_valid[0][c]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (src_ready[0][c] !== 1'b1) begin n_err++; $display("FAIL release_in_ready ch%0d got %b want 1", c, src_ready[0][c]); end
        end
    endtask
    task automatic test_basic();
        for (int c = 0; c < 5; c++) begin
            src_valid[0][c] = 1'b1;
            src_data[0][c] = BASIC[c];
            @(negedge clk);
            src_valid[0][c] = 1'b0;
            n_cmp += 2;
            if (snk_valid[0][c] !== 1'b1) begin n_err++; $display("FAIL basic_valid ch%0d got %b want 1", c, snk_valid[0][c]); end
            if (snk_data[0][c] !== BASIC[c]) begin n_err++; $display("FAIL basic_data ch%0d got %h want %h", c, snk_data[0][c], BASIC[c]); end
            @(negedge clk);
            n_cmp++;
            if (snk_valid[0][c] !== 1'b0) begin n_err++; $display("FAIL basic_drain ch%0d got %b want 0", c, snk_valid[0][c]); end
        end
    endtask
    task automatic test_backpressure();
        logic [35:0] a, b;
        for (int c = 0; c < 5; c++) begin
            a = rnd_pay(c);
            b = rnd_pay(c);
            snk_ready[0][c] = 1'b0;
            src_valid[0][c] = 1'b1;
            src_data[0][c] = a;
            @(negedge clk);
            n_cmp += 2;
            if (src_ready[0][c] !== 1'b1) begin n_err++; $display("FAIL bp_ready_1st ch%0d got %b want 1", c, src_ready[0][c]); end
            if (snk_data[0][c] !== a || snk_valid[0][c] !== 1'b1) begin n_err++; $display("FAIL bp_head_1st ch%0d got %b/%h want 1/%h", c, snk_valid[0][c], snk_data[0][c], a); end
            src_data[0][c] = b;
            @(negedge clk);
            src_valid[0][c] = 1'b0;
            n_cmp += 2;
            if (src_ready[0][c] !== 1'b0) begin n_err++; $display("FAIL bp_ready_full ch%0d got %b want 0", c, src_ready[0][c]); end
            if (snk_data[0][c] !== a || snk_valid[0][c] !== 1'b1) begin n_err++; $display("FAIL bp_head_2nd ch%0d got %b/%h want 1/%h", c, snk_valid[0][c], snk_data[0][c], a); end
            @(negedge clk);
            n_cmp += 2;
            if (src_ready[0][c] !== 1'b0) begin n_err++; $display("FAIL bp_ready_hold ch%0d got %b want 0", c, src_ready[0][c]); end
            if (snk_data[0][c] !== a || snk_valid[0][c] !== 1'b1) begin n_err++; $display("FAIL bp_stable ch%0d got %b/%h want 1/%h", c, snk_valid[0][c], snk_data[0][c], a); end
            snk_ready[0][c] = 1'b1;
            @(negedge clk);
            n_cmp += 2;
            if (src_ready[0][c] !== 1'b1) begin n_err++; $display("FAIL bp_ready_reassert ch%0d got %b want 1", c, src_ready[0][c]); end
            if (snk_data[0][c] !== b || snk_valid[0][c] !== 1'b1) begin n_err++; $display("FAIL bp_second_beat ch%0d got %b/%h want 1/%h", c, snk_valid[0][c], snk_data[0][c], b); end
            @(negedge clk);
            n_cmp++;
            if (snk_valid[0][c] !== 1'b0) begin n_err++; $display("FAIL bp_drain ch%0d got %b want 0", c, snk_valid[0][c]); end
        end
    endtask
    task automatic test_stream();
        logic [35:0] pay [16];
        for (int i = 0; i < 16; i++) pay[i] = rnd_pay(3);
        src_valid[0][3] = 1'b1;
        src_data[0][3] = pay[0];
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_cmp += 2;
            if (snk_valid[0][3] !== 1'b1 || snk_data[0][3] !== pay[k-1]) begin n_err++; $display("FAIL stream_beat %0d got %b/%h want 1/%h", k - 1, snk_valid[0][3], snk_data[0][3], pay[k-1]); end
            if (src_ready[0][3] !== 1'b1) begin n_err++; $display("FAIL stream_ready %0d got %b want 1", k, src_ready[0][3]); end
            if (k < 16) src_data[0][3] = pay[k];
            else src_valid[0][3] = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (snk_valid[0][3] !== 1'b0) begin n_err++; $display("FAIL stream_end got %b want 0", snk_valid[0][3]); end
    endtask
    task automatic test_random();
        int sent [5];
        int recv [5];
        logic fire_in [5];
        logic fire_out [5];
        logic stall [5];
        logic [35:0] prev_d [5];
        bit done;
        for (int c = 0; c < 5; c++) begin
            sent[c] = 0; recv[c] = 0; fire_in[c] = 1'b0; fire_out[c] = 1'b0; stall[c] = 1'b0; prev_d[c] = '0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            done = 1'b1;
            for (int c = 0; c < 5; c++) begin
                if (fire_in[c]) begin sent[c]++; src_valid[0][c] = 1'b0; end
                if (fire_out[c]) recv[c]++;
                if (recv[c] < 100) done = 1'b0;
            end
            if (done) break;
            for (int c = 0; c < 5; c++) begin
                n_cmp += 2;
                if (src_ready[0][c] !== (mq[c].size() < 2)) begin n_err++; $display("FAIL rnd_ready ch%0d cyc %0d got %b want %b", c, cyc, src_ready[0][c], mq[c].size() < 2); end
                if (snk_valid[0][c] !== (mq[c].size() > 0)) begin n_err++; $display("FAIL rnd_valid ch%0d cyc %0d got %b want %b", c, cyc, snk_valid[0][c], mq[c].size() > 0); end
                if (snk_valid[0][c] === 1'b1 && mq[c].size() > 0) begin
                    n_cmp++;
                    if (snk_data[0][c] !== mq[c][0]) begin n_err++; $display("FAIL rnd_order ch%0d cyc %0d got %h want %h", c, cyc, snk_data[0][c], mq[c][0]); end
                end
                if (stall[c]) begin
                    n_cmp++;
                    if (snk_valid[0][c] !== 1'b1 || snk_data[0][c] !== prev_d[c]) begin n_err++; $display("FAIL rnd_stall ch%0d cyc %0d got %b/%h want 1/%h", c, cyc, snk_valid[0][c], snk_data[0][c], prev_d[c]); end
                end
                if (!src_valid[0][c] && sent[c] < 100 && $urandom_range(1, 0) == 1) begin
                    src_valid[0][c] = 1'b1;
                    src_data[0][c] = rnd_pay(c);
                end
                snk_ready[0][c] = ($urandom_range(2, 0) != 0);
                fire_in[c] = src_valid[0][c] && src_ready[0][c];
                fire_out[c] = snk_valid[0][c] && snk_ready[0][c];
                stall[c] = snk_valid[0][c] && !snk_ready[0][c];
                prev_d[c] = snk_data[0][c];
            end
        end
        for (int c = 0; c < 5; c++) begin
            src_valid[0][c] = 1'b0;
            snk_ready[0][c] = 1'b1;
            n_cmp += 2;
            if (recv[c] != 100) begin n_err++; $display("FAIL rnd_count ch%0d got %0d want 100", c, recv[c]); end
            if (mq[c].size() != 0) begin n_err++; $display("FAIL rnd_leftover ch%0d got %0d want 0", c, mq[c].size()); end
        end
    endtask
    task automatic test_bypass();
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            src_valid[1][c] = 1'b1;
            src_data[1][c] = BASIC[c];
            snk_ready[1][c] = 1'b1;
            #1;
            n_cmp += 3;
            if (snk_valid[1][c] !== 1'b1) begin n_err++; $display("FAIL byp_valid ch%0d got %b want 1", c, snk_valid[1][c]); end
            if (snk_data[1][c] !== BASIC[c]) begin n_err++; $display("FAIL byp_data ch%0d got %h want %h", c, snk_data[1][c], BASIC[c]); end
            if (src_ready[1][c] !== 1'b1) begin n_err++; $display("FAIL byp_ready_hi ch%0d got %b want 1", c, src_ready[1][c]); end
            snk_ready[1][c] = 1'b0;
            #1;
            n_cmp++;
            if (src_ready[1][c] !== 1'b0) begin n_err++; $display("FAIL byp_ready_lo ch%0d got %b want 0", c, src_ready[1][c]); end
            src_valid[1][c] = 1'b0;
            #1;
            n_cmp++;
            if (snk_valid[1][c] !== 1'b0) begin n_err++; $display("FAIL byp_valid_lo ch%0d got %b want 0", c, snk_valid[1][c]); end
        end
    endtask
    task automatic test_reset_mid();
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            snk_ready[0][c] = 1'b0;
            src_valid[0][c] = 1'b1;
            src_data[0][c] = rnd_pay(c);
        end
        @(negedge clk);
        for (int c = 0; c < 5; c++) src_data[0][c] = rnd_pay(c);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            src_valid[0][c] = 1'b0;
            n_cmp += 2;
            if (src_ready[0][c] !== 1'b0) begin n_err++; $display("FAIL mid_full_ready ch%0d got %b want 0", c, src_ready[0][c]); end
            if (snk_valid[0][c] !== 1'b1) begin n_err++; $display("FAIL mid_full_valid ch%0d got %b want 1", c, snk_valid[0][c]); end
        end
        #2 rst_n = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            n_cmp += 2;
            if (snk_valid[0][c] !== 1'b0) begin n_err++; $display("FAIL mid_async_valid ch%0d got %b want 0", c, snk_valid[0][c]); end
            if (src_ready[0][c] !== 1'b0) begin n_err++; $display("FAIL mid_async_ready ch%0d got %b want 0", c, src_ready[0][c]); end
        end
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) snk_ready[0][c] = 1'b1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int c = 0; c < 5; c++) begin
                n_cmp += 2;
                if (src_ready[0][c] !== 1'b1) begin n_err++; $display("FAIL mid_release_ready ch%0d got %b want 1", c, src_ready[0][c]); end
                if (snk_valid[0][c] !== 1'b0) begin n_err++; $display("FAIL mid_stale_beat ch%0d got %b want 0", c, snk_valid[0][c]); end
            end
        end
    endtask
    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 5; c++) begin
                src_valid[d][c] = 1'b0;
                src_data[d][c] = '0;
                snk_ready[d][c] = (d == 0);
            end
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_stream();
        test_random();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
